// File: rtl/store_hash_scheduler_pkg.sv
// store_hash_scheduler_pkg: shared types for the load/store ordering scheduler
package store_hash_scheduler_pkg;
   typedef logic [3:0] addr_hash_t;
   typedef enum logic {SCHED_IDLE, SCHED_WAIT} store_sched_state_t;
endpackage

// File: rtl/store_hash_scheduler_addr_hash.sv
// store_hash_scheduler_addr_hash: folds addr[11:2] into a 4-bit hash, bit k collects addr[k+2], addr[k+6], addr[k+10]
module store_hash_scheduler_addr_hash
   import store_hash_scheduler_pkg::*;
#(
   parameter bit USE_BIT_3 = 1'b1
) (
   input  logic [11:0] addr_i,
   output addr_hash_t  hash_o
);
   assign hash_o[0] = (USE_BIT_3 & addr_i[2]) ^ addr_i[6] ^ addr_i[10];
   assign hash_o[1] = addr_i[3] ^ addr_i[7] ^ addr_i[11];
   assign hash_o[2] = addr_i[4] ^ addr_i[8];
   assign hash_o[3] = addr_i[5] ^ addr_i[9];
endmodule

// File: rtl/store_hash_scheduler.sv
// store_hash_scheduler: in-order queue of unretired store hashes; holds each load until
// every older store with a matching hash has retired
module store_hash_scheduler
   import store_hash_scheduler_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter bit USE_BIT_3 = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         st_valid_i,
   input  logic [11:0]                  st_addr_i,
   output logic                         st_ready_o,
   input  logic                         st_retire_i,
   input  logic                         ld_valid_i,
   input  logic [11:0]                  ld_addr_i,
   output logic                         ld_ready_o,
   output logic                         ld_blocked_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   addr_hash_t         hash_q [DEPTH];
   logic [DEPTH-1:0]   valid_q, match;
   logic [PW-1:0]      head_q, tail_q;
   logic [CW-1:0]      count_q, drain_q, drain_init;
   store_sched_state_t state_q;
   addr_hash_t         st_hash, ld_hash;
   logic               st_acc, ret;
   store_hash_scheduler_addr_hash #(.USE_BIT_3(USE_BIT_3)) u_st_hash (.addr_i(st_addr_i), .hash_o(st_hash));
   store_hash_scheduler_addr_hash #(.USE_BIT_3(USE_BIT_3)) u_ld_hash (.addr_i(ld_addr_i), .hash_o(ld_hash));
   assign st_ready_o   = count_q != CW'(DEPTH);
   assign st_acc       = st_valid_i & st_ready_o;
   assign ret          = st_retire_i & (count_q != '0);
   assign empty_o      = count_q == '0;
   assign count_o      = count_q;
   assign ld_blocked_o = state_q == SCHED_WAIT;
   assign ld_ready_o   = rst_n & ld_valid_i & (ld_blocked_o ? drain_q == '0 : ~|match);
   always_comb begin
      for (int k = 0; k < DEPTH; k++) match[k] = valid_q[k] & (hash_q[k] == ld_hash);
   end
   // Later offsets from head overwrite earlier ones, leaving the youngest match
   always_comb begin
      drain_init = '0;
      for (int k = 0; k < DEPTH; k++) if (match[PW'(head_q + PW'(k))]) drain_init = CW'(k + 1);
   end
   always_ff @(posedge clk) begin
      if (st_acc) hash_q[tail_q] <= st_hash;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         drain_q <= '0;
         state_q <= SCHED_IDLE;
      end else begin
         if (st_acc) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + PW'(1);
         end
         if (ret) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PW'(1);
         end
         count_q <= count_q + CW'(st_acc) - CW'(ret);
         if (state_q == SCHED_IDLE) begin
            if (ld_valid_i && |match) begin
               state_q <= SCHED_WAIT;
               drain_q <= drain_init - CW'(ret);
            end
         end else if (!ld_valid_i || ld_ready_o) begin
            state_q <= SCHED_IDLE;
            drain_q <= '0;
         end else if (ret && drain_q != '0) begin
            drain_q <= drain_q - CW'(1);
         end
      end
   end
   retire_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(st_retire_i && count_q == '0));
endmodule

// File: tb/tb_store_hash_scheduler.sv
// tb_store_hash_scheduler: directed vector table, reset sequence and randomized run
// checked against a sequence-number model of store/load ordering
module tb_store_hash_scheduler;
   localparam bit USE_BIT_3 = 1'b1;
   logic clk = 0, rst_n = 0, st_valid = 0, st_retire = 0, ld_valid = 0;
   logic [11:0] st_addr = '0, ld_addr = '0;
   logic st_ready, ld_ready, ld_blocked, empty;
   logic [2:0] count;
   int n_vec = 0, n_err = 0;
   store_hash_scheduler #(.DEPTH(4), .USE_BIT_3(USE_BIT_3)) dut (
      .clk(clk), .rst_n(rst_n), .st_valid_i(st_valid), .st_addr_i(st_addr), .st_ready_o(st_ready),
      .st_retire_i(st_retire), .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_ready_o(ld_ready),
      .ld_blocked_o(ld_blocked), .empty_o(empty), .count_o(count));
   always #5 clk = ~clk;
   typedef struct {int seq; logic [3:0] h;} ment_t;
   typedef struct {logic sv; logic [11:0] sa; logic sr; logic lv; logic [11:0] la;
                   logic e_sr; logic e_lr; logic e_bl; logic [2:0] e_cnt;} vec_t;
   ment_t mq[$];
   vec_t  tab[$];
   int next_seq = 0, retired = 0, barrier = 0;
   bit mwait = 0, last_hs = 0;
   function automatic logic [3:0] mhash(input logic [11:0] a);
      logic [3:0] h = '0;
      for (int b = 2; b < 12; b++) if (a[b] && (b != 2 || USE_BIT_3)) h[(b - 2) % 4] ^= 1'b1;
      return h;
   endfunction
   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic v(input logic sv, input logic [11:0] sa, input logic sr, input logic lv, input logic [11:0] la,
                    input logic e_sr, input logic e_lr, input logic e_bl, input logic [2:0] e_cnt);
      tab.push_back('{sv, sa, sr, lv, la, e_sr, e_lr, e_bl, e_cnt});
   endtask
   task automatic model_reset();
      mq.delete();
      next_seq = 0;
      retired  = 0;
      mwait    = 0;
   endtask
   task automatic cycle(input bit use_tab, input vec_t t, input string tag);
      bit hm, m_lr, m_sr, acc, ret;
      int bar;
      @(negedge clk);
      m_sr = mq.size() < 4;
      hm = 0;
      bar = -1;
      foreach (mq[i]) if (mq[i].h == mhash(ld_addr)) begin hm = 1; bar = mq[i].seq; end
      m_lr = ld_valid && (mwait ? retired > barrier : !hm);
      if (use_tab) begin
         chk({tag, ".st_ready"}, st_ready, t.e_sr);
         chk({tag, ".ld_ready"}, ld_ready, t.e_lr);
         chk({tag, ".ld_blocked"}, ld_blocked, t.e_bl);
         chk({tag, ".count"}, count, t.e_cnt);
      end else begin
         chk({tag, ".st_ready"}, st_ready, m_sr);
         chk({tag, ".ld_ready"}, ld_ready, m_lr);
         chk({tag, ".ld_blocked"}, ld_blocked, mwait);
         chk({tag, ".count"}, count, mq.size());
         chk({tag, ".empty"}, empty, mq.size() == 0);
      end
      last_hs = m_lr;
      acc = st_valid && m_sr;
      ret = st_retire && mq.size() > 0;
      if (!mwait) begin
         if (ld_valid && hm) begin mwait = 1; barrier = bar; end
      end else if (!ld_valid || m_lr) mwait = 0;
      if (ret) begin void'(mq.pop_front()); retired++; end
      if (acc) begin mq.push_back('{next_seq, mhash(st_addr)}); next_seq++; end
      @(posedge clk);
      #1;
   endtask
   task automatic apply(input vec_t t);
      st_valid = t.sv; st_addr = t.sa; st_retire = t.sr; ld_valid = t.lv; ld_addr = t.la;
   endtask
   function automatic logic [11:0] pick();
      logic [11:0] r = 12'($urandom());
      case ($urandom_range(0, 7))
         0: return 12'h010;
         1: return 12'h040;
         2: return 12'h100;
         3: return 12'h020;
         4: return 12'h004;
         5: return 12'h000;
         6: return 12'h104;
         default: return r;
      endcase
   endfunction
   initial begin
      vec_t t;
      bit pend = 0;
      v(0,12'h000,0,1,12'h104, 1,1,0,0); v(1,12'h040,0,0,12'h000, 1,0,0,0);
      v(0,12'h000,0,1,12'h040, 1,0,0,1); v(0,12'h000,1,1,12'h040, 1,0,1,1);
      v(0,12'h000,0,1,12'h040, 1,1,1,0); v(0,12'h000,0,0,12'h000, 1,0,0,0);
      v(1,12'h010,0,0,12'h000, 1,0,0,0); v(1,12'h040,0,0,12'h000, 1,0,0,1);
      v(1,12'h010,0,0,12'h000, 1,0,0,2); v(0,12'h000,0,1,12'h010, 1,0,0,3);
      v(0,12'h000,1,1,12'h010, 1,0,1,3); v(1,12'h010,1,1,12'h010, 1,0,1,2);
      v(0,12'h000,1,1,12'h010, 1,0,1,2); v(0,12'h000,0,1,12'h010, 1,1,1,1);
      v(0,12'h000,0,0,12'h000, 1,0,0,1); v(0,12'h000,1,0,12'h000, 1,0,0,1);
      v(1,12'h001,0,0,12'h000, 1,0,0,0); v(1,12'h002,0,0,12'h000, 1,0,0,1);
      v(1,12'h003,0,0,12'h000, 1,0,0,2); v(1,12'h004,0,0,12'h000, 1,0,0,3);
      v(1,12'h005,1,0,12'h000, 0,0,0,4); v(1,12'h010,0,0,12'h000, 1,0,0,3);
      v(0,12'h000,1,1,12'h010, 0,0,0,4); v(0,12'h000,1,1,12'h010, 1,0,1,3);
      v(0,12'h000,1,1,12'h010, 1,0,1,2); v(0,12'h000,1,1,12'h010, 1,0,1,1);
      v(0,12'h000,0,1,12'h010, 1,1,1,0); v(1,12'h010,0,0,12'h000, 1,0,0,0);
      v(0,12'h000,0,1,12'h100, 1,0,0,1); v(0,12'h000,1,1,12'h100, 1,0,1,1);
      v(0,12'h000,0,1,12'h100, 1,1,1,0); v(1,12'h010,0,0,12'h000, 1,0,0,0);
      v(0,12'h000,0,1,12'h020, 1,1,0,1); v(0,12'h000,0,1,12'h100, 1,0,0,1);
      v(0,12'h000,0,0,12'h000, 1,0,1,1); v(0,12'h000,1,0,12'h000, 1,0,0,1);
      v(1,12'h040,0,1,12'h040, 1,1,0,0); v(0,12'h000,1,0,12'h000, 1,0,0,1);
      ld_valid = 1;
      ld_addr  = 12'h104;
      #12;
      chk("reset.st_ready", st_ready, 1);
      chk("reset.ld_ready", ld_ready, 0);
      chk("reset.ld_blocked", ld_blocked, 0);
      chk("reset.empty", empty, 1);
      chk("reset.count", count, 0);
      ld_valid = 0;
      @(negedge clk) rst_n = 1;
      @(posedge clk);
      #1;
      foreach (tab[i]) begin
         apply(tab[i]);
         cycle(1, tab[i], $sformatf("vec%0d", i));
      end
      t = '{1,12'h010,0,0,12'h000, 1,0,0,0};
      apply(t); cycle(0, t, "rst_seq.st0");
      apply(t); cycle(0, t, "rst_seq.st1");
      t = '{0,12'h000,0,1,12'h010, 1,0,0,2};
      apply(t); cycle(0, t, "rst_seq.ld");
      apply(t); cycle(0, t, "rst_seq.wait");
      rst_n = 0;
      #2;
      chk("midreset.ld_blocked", ld_blocked, 0);
      chk("midreset.count", count, 0);
      chk("midreset.st_ready", st_ready, 1);
      chk("midreset.ld_ready", ld_ready, 0);
      chk("midreset.empty", empty, 1);
      model_reset();
      @(negedge clk) rst_n = 1;
      @(posedge clk);
      #1;
      t = '{0,12'h000,0,1,12'h010, 1,1,0,0};
      apply(t); cycle(1, t, "postreset.ld");
      for (int c = 0; c < 600; c++) begin
         st_valid  = 1'($urandom_range(0, 1));
         st_addr   = pick();
         st_retire = mq.size() > 0 && $urandom_range(0, 2) == 0;
         if (pend && $urandom_range(0, 9) != 0) ld_valid = 1;
         else begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr  = pick();
         end
         cycle(0, t, $sformatf("rnd%0d", c));
         pend = ld_valid && !last_hs;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
